// File: rtl/sbp_pkg.sv
// Shared types and default widths for the stage memory arbiter and lookup stage.
package sbp_pkg;

  localparam int unsigned SBP_ADDR_BITS = 11;
  localparam int unsigned SBP_DATA_BITS = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                     write;
    logic [SBP_ADDR_BITS-1:0] addr;
    logic [SBP_DATA_BITS-1:0] wdata;
  } cp_req_t;

endpackage

// File: rtl/sbp_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sbp_sat_counter #(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sbp_stage_mem_arbiter.sv
// Shares one stage RAM port: lookups always win, control-plane ops fill idle slots,
// and a starvation counter asks ingress for a bubble when an op waits too long.
module sbp_stage_mem_arbiter
  import sbp_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = SBP_ADDR_BITS,
  parameter int unsigned DATA_BITS    = SBP_DATA_BITS,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lu_valid_i,
  input  logic [ADDR_BITS-1:0] lu_addr_i,
  output logic [DATA_BITS-1:0] lu_data_o,
  input  logic                 cp_valid_i,
  output logic                 cp_ready_o,
  input  logic                 cp_write_i,
  input  logic [ADDR_BITS-1:0] cp_addr_i,
  input  logic [DATA_BITS-1:0] cp_wdata_i,
  output logic                 cp_done_o,
  output logic [DATA_BITS-1:0] cp_rdata_o,
  output logic                 bubble_req_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [DATA_BITS-1:0] mem_wdata_o,
  input  logic [DATA_BITS-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  cp_req_t          hold;
  logic             accept;
  logic             issue;
  logic [CNT_W-1:0] starve_cnt;

  sbp_sat_counter #(
    .MAX (STARVE_LIMIT),
    .W   (CNT_W)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   ((state == PEND) && lu_valid_i),
    .count (starve_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    issue      = 1'b0;
    cp_ready_o = 1'b0;
    case (state)
      IDLE: begin
        cp_ready_o = 1'b1;
        if (cp_valid_i) begin
          accept    = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (!lu_valid_i) begin
          issue     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Port mux: a lookup owns the port whenever it is valid, whatever the state.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = lu_addr_i;
    mem_wdata_o = DATA_BITS'(hold.wdata);
    if (lu_valid_i) begin
      mem_en_o = 1'b1;
    end else if (issue) begin
      mem_en_o   = 1'b1;
      mem_we_o   = hold.write;
      mem_addr_o = ADDR_BITS'(hold.addr);
    end
  end

  assign lu_data_o = mem_rdata_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold         <= '0;
      cp_done_o    <= 1'b0;
      cp_rdata_o   <= '0;
      bubble_req_o <= 1'b0;
    end else begin
      cp_done_o <= (state == RESP);
      if (accept) begin
        hold <= '{write: cp_write_i,
                  addr:  SBP_ADDR_BITS'(cp_addr_i),
                  wdata: SBP_DATA_BITS'(cp_wdata_i)};
      end
      // Read data is on mem_rdata_i during RESP, one cycle after issue.
      if (state == RESP) begin
        bubble_req_o <= 1'b0;
        if (!hold.write) begin
          cp_rdata_o <= mem_rdata_i;
        end
      end else if ((state == PEND) && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
        bubble_req_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sbp_stage_mem_arbiter.sv
// Directed bench for sbp_stage_mem_arbiter with a behavioural 1-cycle-latency stage RAM.
module tb_sbp_stage_mem_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 64;

  localparam logic [DW-1:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] D2 = 64'hDEAD_BEEF_0000_0002;
  localparam logic [DW-1:0] D3 = 64'hCAFE_F00D_0000_0003;
  localparam logic [DW-1:0] D4 = 64'h5A5A_0000_0000_07FF;
  localparam logic [DW-1:0] D5 = 64'h1111_2222_3333_4444;
  localparam logic [DW-1:0] D6 = 64'h9999_8888_7777_6666;

  logic          clk;
  logic          rst;
  logic          lu_valid;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          cp_valid;
  logic          cp_ready;
  logic          cp_write;
  logic [AW-1:0] cp_addr;
  logic [DW-1:0] cp_wdata;
  logic          cp_done;
  logic [DW-1:0] cp_rdata;
  logic          bubble_req;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks;
  int errors;

  sbp_stage_mem_arbiter #(
    .ADDR_BITS    (AW),
    .DATA_BITS    (DW),
    .STARVE_LIMIT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lu_valid_i   (lu_valid),
    .lu_addr_i    (lu_addr),
    .lu_data_o    (lu_data),
    .cp_valid_i   (cp_valid),
    .cp_ready_o   (cp_ready),
    .cp_write_i   (cp_write),
    .cp_addr_i    (cp_addr),
    .cp_wdata_i   (cp_wdata),
    .cp_done_o    (cp_done),
    .cp_rdata_o   (cp_rdata),
    .bubble_req_o (bubble_req),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage RAM model with registered read; also counts writes to the address used by the reset test.
  logic [DW-1:0] mem [2048];
  logic          init_mem;
  int            w300;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
      mem[11'h7FF] <= D4;
      mem_rdata    <= '0;
      w300         <= 0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        if (mem_addr == 11'h300) w300 <= w300 + 1;
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          lv;
    logic [AW-1:0] la;
    logic          cv;
    logic          cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_rdy;
    logic          e_done;
    logic [DW-1:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic lv, input logic [AW-1:0] la, input logic cv,
                              input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                              input logic e_en, input logic e_we, input logic [AW-1:0] e_addr,
                              input logic [DW-1:0] e_wd, input logic e_rdy, input logic e_done,
                              input logic [DW-1:0] e_rdata);
    vec_t v;
    v.lv = lv; v.la = la; v.cv = cv; v.cw = cw; v.ca = ca; v.cd = cd;
    v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_rdy = e_rdy; v.e_done = e_done; v.e_rdata = e_rdata;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    init_mem = 1'b1;
    lu_valid = 1'b0;
    lu_addr  = '0;
    cp_valid = 1'b0;
    cp_write = 1'b0;
    cp_addr  = '0;
    cp_wdata = '0;

    // Write/read round trip, back-to-back queue, then a read threaded between lookups.
    vecs.push_back(mk(0, 11'h033, 1, 1, 11'h005, D1, 0, 0, 11'h033, '0, 1, 0, '0));
    vecs.push_back(mk(0, 11'h033, 0, 0, 11'h000, '0, 1, 1, 11'h005, D1, 0, 0, '0));
    vecs.push_back(mk(0, 11'h033, 0, 0, 11'h000, '0, 0, 0, 11'h033, '0, 0, 0, '0));
    vecs.push_back(mk(0, 11'h033, 1, 0, 11'h005, '0, 0, 0, 11'h033, '0, 1, 1, '0));
    vecs.push_back(mk(0, 11'h033, 0, 0, 11'h000, '0, 1, 0, 11'h005, '0, 0, 0, '0));
    vecs.push_back(mk(0, 11'h033, 0, 0, 11'h000, '0, 0, 0, 11'h033, '0, 0, 0, '0));
    vecs.push_back(mk(0, 11'h033, 0, 0, 11'h000, '0, 0, 0, 11'h033, '0, 1, 1, D1));
    vecs.push_back(mk(0, 11'h033, 1, 1, 11'h100, D2, 0, 0, 11'h033, '0, 1, 0, D1));
    vecs.push_back(mk(0, 11'h033, 1, 1, 11'h101, D3, 1, 1, 11'h100, D2, 0, 0, D1));
    vecs.push_back(mk(0, 11'h033, 1, 1, 11'h101, D3, 0, 0, 11'h033, '0, 0, 0, D1));
    vecs.push_back(mk(0, 11'h033, 1, 1, 11'h101, D3, 0, 0, 11'h033, '0, 1, 1, D1));
    vecs.push_back(mk(0, 11'h033, 1, 0, 11'h100, '0, 1, 1, 11'h101, D3, 0, 0, D1));
    vecs.push_back(mk(0, 11'h033, 1, 0, 11'h100, '0, 0, 0, 11'h033, '0, 0, 0, D1));
    vecs.push_back(mk(0, 11'h033, 1, 0, 11'h100, '0, 0, 0, 11'h033, '0, 1, 1, D1));
    vecs.push_back(mk(0, 11'h033, 0, 0, 11'h000, '0, 1, 0, 11'h100, '0, 0, 0, D1));
    vecs.push_back(mk(0, 11'h033, 0, 0, 11'h000, '0, 0, 0, 11'h033, '0, 0, 0, D1));
    vecs.push_back(mk(0, 11'h033, 0, 0, 11'h000, '0, 0, 0, 11'h033, '0, 1, 1, D2));
    vecs.push_back(mk(1, 11'h020, 1, 0, 11'h7FF, '0, 1, 0, 11'h020, '0, 1, 0, D2));
    vecs.push_back(mk(1, 11'h021, 0, 0, 11'h000, '0, 1, 0, 11'h021, '0, 0, 0, D2));
    vecs.push_back(mk(0, 11'h021, 0, 0, 11'h000, '0, 1, 0, 11'h7FF, '0, 0, 0, D2));
    vecs.push_back(mk(1, 11'h022, 0, 0, 11'h000, '0, 1, 0, 11'h022, '0, 0, 0, D2));
    vecs.push_back(mk(0, 11'h022, 0, 0, 11'h000, '0, 0, 0, 11'h022, '0, 1, 1, D4));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    init_mem = 1'b0;
    #1;
    chk("reset cp_ready", 64'(cp_ready), 64'd1);
    chk("reset cp_done", 64'(cp_done), 64'd0);
    chk("reset bubble_req", 64'(bubble_req), 64'd0);
    chk("reset cp_rdata", cp_rdata, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      lu_valid = vecs[i].lv;
      lu_addr  = vecs[i].la;
      cp_valid = vecs[i].cv;
      cp_write = vecs[i].cw;
      cp_addr  = vecs[i].ca;
      cp_wdata = vecs[i].cd;
      #1;
      chk($sformatf("row%0d mem_en", i), 64'(mem_en), 64'(vecs[i].e_en));
      chk($sformatf("row%0d mem_we", i), 64'(mem_we), 64'(vecs[i].e_we));
      chk($sformatf("row%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_addr));
      if (vecs[i].e_we) chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_wd);
      chk($sformatf("row%0d cp_ready", i), 64'(cp_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("row%0d cp_done", i), 64'(cp_done), 64'(vecs[i].e_done));
      chk($sformatf("row%0d bubble_req", i), 64'(bubble_req), 64'd0);
      chk($sformatf("row%0d cp_rdata", i), cp_rdata, vecs[i].e_rdata);
      chk($sformatf("row%0d lu_data", i), lu_data, mem_rdata);
    end

    // Starvation: continuous lookups hold off a pending write until one idle slot.
    @(negedge clk);
    lu_valid = 1'b1; lu_addr = 11'h010;
    cp_valid = 1'b1; cp_write = 1'b1; cp_addr = 11'h200; cp_wdata = D5;
    #1;
    chk("starve accept ready", 64'(cp_ready), 64'd1);
    for (int p = 1; p <= 24; p++) begin
      @(negedge clk);
      cp_valid = 1'b0;
      #1;
      chk($sformatf("starve p%0d mem_addr", p), 64'(mem_addr), 64'h010);
      chk($sformatf("starve p%0d mem_we", p), 64'(mem_we), 64'd0);
      chk($sformatf("starve p%0d cp_ready", p), 64'(cp_ready), 64'd0);
      if (p == 16) chk("starve bubble before limit", 64'(bubble_req), 64'd0);
      if (p == 18) chk("starve bubble after limit", 64'(bubble_req), 64'd1);
    end
    @(negedge clk);
    lu_valid = 1'b0;
    #1;
    chk("starve issue mem_en", 64'(mem_en), 64'd1);
    chk("starve issue mem_we", 64'(mem_we), 64'd1);
    chk("starve issue mem_addr", 64'(mem_addr), 64'h200);
    chk("starve issue mem_wdata", mem_wdata, D5);
    chk("starve issue bubble", 64'(bubble_req), 64'd1);
    @(negedge clk);
    lu_valid = 1'b1;
    #1;
    chk("starve resp mem_we", 64'(mem_we), 64'd0);
    chk("starve resp cp_done", 64'(cp_done), 64'd0);
    @(negedge clk);
    lu_valid = 1'b0;
    #1;
    chk("starve done", 64'(cp_done), 64'd1);
    chk("starve done bubble", 64'(bubble_req), 64'd0);
    chk("starve done ready", 64'(cp_ready), 64'd1);
    chk("starve done rdata held", cp_rdata, D4);
    chk("starve write landed", mem[11'h200], D5);

    // Reset while a starved write is pending: op is dropped silently.
    @(negedge clk);
    lu_valid = 1'b1; lu_addr = 11'h010;
    cp_valid = 1'b1; cp_write = 1'b1; cp_addr = 11'h300; cp_wdata = D6;
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      cp_valid = 1'b0;
    end
    #1;
    chk("pre-reset bubble", 64'(bubble_req), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    lu_valid = 1'b0;
    #1;
    chk("post-reset cp_ready", 64'(cp_ready), 64'd1);
    chk("post-reset bubble", 64'(bubble_req), 64'd0);
    chk("post-reset cp_done", 64'(cp_done), 64'd0);
    chk("post-reset mem_en", 64'(mem_en), 64'd0);
    chk("post-reset cp_rdata", cp_rdata, 64'd0);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-reset c%0d cp_done", p), 64'(cp_done), 64'd0);
      chk($sformatf("post-reset c%0d mem_we", p), 64'(mem_we), 64'd0);
    end
    chk("dropped write count", 64'(w300), 64'd0);
    chk("dropped write data", mem[11'h300], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
